// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branch conditions, trains a 2-bit BHT and keeps branch statistics.
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int BHT_DEPTH = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Branch,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_pred,
  output logic             valid_out,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [1:0] bht [BHT_DEPTH];
  logic [IW-1:0] idx, lidx;
  logic eq, lt, ltu, base, res, ill, fire, miss;
  logic unused_ok;
  assign idx = pc[IW+1:2];
  assign lidx = lookup_pc[IW+1:2];
  assign unused_ok = ^{pc[XLEN-1:IW+2], pc[1:0], lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};
  assign eq = rs1_val == rs2_val;
  assign lt = $signed(rs1_val) < $signed(rs2_val);
  assign ltu = rs1_val < rs2_val;
  // funct3[2:1] picks the comparison, funct3[0] inverts it; 01x is the illegal pair
  always_comb begin
    base = funct3[2] ? (funct3[1] ? ltu : lt) : eq;
    ill = funct3[2:1] == 2'b01;
    res = !ill && (base ^ funct3[0]);
    fire = Branch && !flush;
    miss = fire && !ill && (res != pred_taken);
  end
  assign lookup_pred = bht[lidx][1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      taken <= 1'b0;
      mispredict <= 1'b0;
      illegal <= 1'b0;
      branch_count <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else begin
      valid_out <= fire;
      taken <= fire && res;
      mispredict <= miss;
      illegal <= fire && ill;
      if (fire && !(&branch_count)) branch_count <= branch_count + 1'b1;
      if (miss && !(&mispredict_count)) mispredict_count <= mispredict_count + 1'b1;
      if (fire && !ill)
        bht[idx] <= res ? ((bht[idx] == 2'd3) ? 2'd3 : bht[idx] + 2'd1)
                        : ((bht[idx] == 2'd0) ? 2'd0 : bht[idx] - 2'd1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks against a behavioural branch/BHT model.
module tb_branch_resolve_unit;
  localparam int D = 16;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, br = 0, fl = 0, pt = 0;
  logic [2:0] f3 = 0;
  logic [31:0] a = 0, b = 0, pc = 0, lpc = 0;
  logic lp, vo, tk, mp, il;
  logic [CW-1:0] bcnt, mcnt;
  int total = 0, bad = 0;
  int m_bht[D];
  int m_bc, m_mc;
  bit e_v, e_t, e_m, e_i;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(D), .CTR_INIT(2'b01), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Branch(br), .flush(fl), .funct3(f3),
    .rs1_val(a), .rs2_val(b), .pc(pc), .pred_taken(pt), .lookup_pc(lpc),
    .lookup_pred(lp), .valid_out(vo), .taken(tk), .mispredict(mp), .illegal(il),
    .branch_count(bcnt), .mispredict_count(mcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return !($signed(x) < $signed(y));
      3'd6: return x < y;
      3'd7: return !(x < y);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_bc = 0; m_mc = 0;
    e_v = 0; e_t = 0; e_m = 0; e_i = 0;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, vo, e_v);
    check({tag, "_taken"}, tk, e_t);
    check({tag, "_misp"}, mp, e_m);
    check({tag, "_illegal"}, il, e_i);
    check({tag, "_bcnt"}, bcnt, m_bc);
    check({tag, "_mcnt"}, mcnt, m_mc);
  endtask

  task automatic cyc(input string tag, input bit b_, input bit fl_, input logic [2:0] f,
                     input logic [31:0] x, input logic [31:0] y, input logic [31:0] p,
                     input bit pt_, input logic [31:0] l_);
    bit fire, ill, t;
    int i;
    br = b_; fl = fl_; f3 = f; a = x; b = y; pc = p; pt = pt_; lpc = l_;
    #1 check({tag, "_lookup"}, lp, m_bht[l_[5:2]] >= 2);
    @(posedge clk);
    fire = b_ && !fl_;
    ill = (f == 3'd2) || (f == 3'd3);
    t = cond_of(f, x, y);
    e_v = fire; e_t = fire && t; e_i = fire && ill; e_m = fire && !ill && (t != pt_);
    if (fire) begin
      if (m_bc < CMAX) m_bc++;
      if (e_m && m_mc < CMAX) m_mc++;
      if (!ill) begin
        i = int'(p[5:2]);
        m_bht[i] = t ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
      end
    end
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0; br = 0;
    #1 model_reset();
    check_out(tag);
    check({tag, "_lk"}, lp, 0);
    #1 rst_n = 1;
    @(negedge clk);
    check_out({tag, "_rel"});
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_out("rst");
    rst_n = 1;
    cyc("beq", 1, 0, 0, 5, 5, 0, 0, 0);
    check("beq_m1", mcnt, 1);
    cyc("blt", 1, 0, 4, 32'hFFFFFFFF, 1, 4, 1, 0);
    check("blt_t", tk, 1);
    cyc("bltu", 1, 0, 6, 32'hFFFFFFFF, 1, 4, 1, 0);
    check("bltu_t", tk, 0);
    for (int k = 0; k < 3; k++) cyc("train_t", 1, 0, 0, 7, 7, 32'h40, 1, 32'h40);
    cyc("look_hi", 0, 0, 0, 0, 0, 0, 0, 32'h40);
    check("look_hi_1", lp, 1);
    for (int k = 0; k < 4; k++) cyc("train_nt", 1, 0, 1, 9, 9, 32'h40, 0, 32'h40);
    cyc("look_lo", 0, 0, 0, 0, 0, 0, 0, 32'h40);
    check("look_lo_0", lp, 0);
    cyc("ill", 1, 0, 2, 1, 2, 32'h44, 1, 32'h44);
    check("ill_flag", il, 1);
    cyc("ill_bht", 0, 0, 0, 0, 0, 0, 0, 32'h44);
    cyc("flush", 1, 1, 0, 3, 3, 32'h48, 0, 32'h48);
    check("flush_v", vo, 0);
    cyc("pre_rst", 1, 0, 0, 3, 3, 32'h48, 0, 32'h48);
    cyc("pre_rst2", 1, 0, 0, 3, 3, 32'h48, 0, 32'h48);
    async_reset("arst");
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 32'h48);
    check("post_rst_lk", lp, 0);
    cyc("b2b", 1, 0, 0, 3, 3, 32'h48, 0, 32'h48);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] x, y, p;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 5) == 0) x = {~x[31], x[30:0]};
      p = {$urandom, 2'b00};
      p[5:2] = 4'($urandom_range(0, 3));
      cyc("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 3'($urandom),
          x, y, p, 1'($urandom), {28'($urandom), 4'($urandom_range(0, 3)) << 2} ^ 32'h0);
      if ($urandom_range(0, 79) == 0) async_reset("rnd_rst");
    end
    for (int n = 0; n < 70; n++) cyc("sat", 1, 0, 0, 1, 1, 32'h50, 0, 32'h50);
    check("sat_b", bcnt, CMAX);
    check("sat_m", mcnt, CMAX);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, meaning number of branch history table entries; a power of two, at least 2.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, meaning the reset value of every 2-bit history counter.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Branch  input  1  a branch resolves this cycle.
REQ-008 flush  input  1  kills the branch presented this cycle.
REQ-009 funct3  input  3  branch condition encoding.
REQ-010 rs1_val, rs2_val  input  XLEN  compare operands.
REQ-011 pc  input  XLEN  address of the resolving branch.
REQ-012 pred_taken  input  1  fetch-time prediction for the resolving branch.
REQ-013 lookup_pc  input  XLEN  fetch address to predict.
REQ-014 lookup_pred  output  1  combinational prediction for lookup_pc.
REQ-015 valid_out  output  1  registered; result outputs valid this cycle.
REQ-016 taken  output  1  registered resolved direction.
REQ-017 mispredict  output  1  registered; taken differs from pred_taken.
REQ-018 illegal  output  1  registered; funct3 is 010 or 011.
REQ-019 branch_count, mispredict_count  output  CNT_W  registered statistics counters.

Function
REQ-020 Compare: eq = (rs1_val == rs2_val); lt = signed rs1_val < rs2_val; ltu = unsigned rs1_val < rs2_val; all at full XLEN width.
REQ-021 Condition by funct3: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 not taken and illegal.
REQ-022 Latency: one cycle; Branch && !flush at edge N drives valid_out=1 for exactly cycle N+1, with taken, mispredict and illegal for that branch.
REQ-023 When no qualifying branch was sampled at the previous edge: valid_out=0, taken=0, mispredict=0, illegal=0.
REQ-024 Branch && flush: no output, no BHT update, no counter change.
REQ-025 BHT index = pc[log2(BHT_DEPTH)+1:2]; the lookup index is formed the same way from lookup_pc.
REQ-026 Counter update on a qualifying branch with a legal funct3, at the same edge as the output register: taken -> +1, saturate at 3; not taken -> -1, saturate at 0.
REQ-027 An illegal funct3 SHALL NOT update the BHT, SHALL NOT assert mispredict, and SHALL increment branch_count.
REQ-028 lookup_pred = MSB of the indexed counter as currently stored; a same-cycle update to the same index is not bypassed, so the pre-update value is returned.
REQ-029 Back-to-back branches every cycle SHALL be accepted with no stall; consecutive same-index updates accumulate.
REQ-030 branch_count increments for each qualifying branch.
REQ-031 mispredict_count increments for each qualifying legal branch whose taken != pred_taken.
REQ-032 Both statistics counters saturate at 2^CNT_W-1 and do not wrap.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock, clear valid_out, taken, mispredict, illegal, branch_count and mispredict_count to 0 and set every BHT counter to CTR_INIT.
REQ-034 Reset mid-operation SHALL discard any in-flight result, so valid_out=0 on the first cycle after release.
REQ-035 The first edge with rst_n=1 samples inputs normally.

Verification
REQ-036 Reset, then beq with rs1=rs2=5, pred_taken=0 -> next cycle valid_out=1, taken=1, mispredict=1; mispredict_count=1.
REQ-037 blt with rs1=0xFFFFFFFF, rs2=1 -> taken=1; bltu with the same operands -> taken=0.
REQ-038 Three taken branches at pc=0x40 -> lookup_pc=0x40 gives lookup_pred 1 after the first update (01->10); the counter saturates at 3; four not-taken updates leave 0.
REQ-039 funct3=010 with Branch=1 -> illegal=1, taken=0, BHT unchanged, branch_count+1.
REQ-040 Branch=1 with flush=1 -> valid_out stays 0 and the counters are unchanged.
REQ-041 rst_n pulsed low between two back-to-back branches -> outputs drop to 0 asynchronously; valid_out=0 on the cycle after release; BHT returns to CTR_INIT.
